// File: rtl/burst_pkg.sv
// Shared definitions for the burst read/write masters: FSM states, burst
// size clamp and the per-beat byte stride.
package burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQUEST,
    ST_RECEIVE,
    ST_FINISH
  } burst_state_e;

  localparam int unsigned BEAT_STRIDE_BYTES = 4;

  // Zero requests one beat; anything above the bus maximum is cut back to it.
  function automatic int unsigned clamp_burst(input int unsigned req,
                                              input int unsigned max_burst);
    if (req == 0) return 1;
    if (req > max_burst) return max_burst;
    return req;
  endfunction

endpackage

// File: rtl/burst_read_master_if.sv
// Avalon-MM read bus plus the outgoing valid/ready stream of the burst read
// master, bundled so the master and its memory/consumer see one port.
interface burst_read_master_if #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int BYTE_ENABLE_WIDTH = 4,
  parameter int BURST_WIDTH       = 4
);
  logic [ADDRESS_WIDTH-1:0]     master_address;
  logic                         master_read;
  logic [BURST_WIDTH-1:0]       master_burstcount;
  logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable;
  logic                         master_waitrequest;
  logic [DATA_WIDTH-1:0]        master_readdata;
  logic                         master_readdatavalid;
  logic [DATA_WIDTH-1:0]        user_data;
  logic                         user_valid;
  logic                         user_ready;

  modport master (
    output master_address, master_read, master_burstcount, master_byteenable,
    output user_data, user_valid,
    input  master_waitrequest, master_readdata, master_readdatavalid,
    input  user_ready
  );

  modport slave (
    input  master_address, master_read, master_burstcount, master_byteenable,
    input  user_data, user_valid,
    output master_waitrequest, master_readdata, master_readdatavalid,
    output user_ready
  );
endinterface

// File: rtl/burst_read_fifo.sv
// Show-ahead synchronous FIFO buffering returned read data; exposes its
// registered occupancy so the master can reserve room before each burst.
module burst_read_fifo #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    pop_data,
  output logic                     empty,
  output logic [FIFO_DEPTH_LOG2:0] count
);
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_C = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  // Output forced to zero while empty so a reset leaves the stream quiet.
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

  assert property (@(posedge clk) disable iff (reset) !(push && count_q == DEPTH_C));
  assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/burst_read_master.sv
// Avalon-MM burst read master feeding a valid/ready stream through a FIFO.
// Define BURST_READ_CHECKSUM_EN to add the ctrl_checksum running-sum output.
module burst_read_master
  import burst_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int BYTE_ENABLE_WIDTH = BEAT_STRIDE_BYTES,
  parameter int BURST_WIDTH       = 4,
  parameter int LENGTH_WIDTH      = 16,
  parameter int FIFO_DEPTH        = 16,
  parameter int FIFO_DEPTH_LOG2   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  burst_read_master_if.master      bus,
  input  logic                     ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0] ctrl_baseaddress,
  input  logic [LENGTH_WIDTH-1:0]  ctrl_length,
  input  logic [BURST_WIDTH-1:0]   ctrl_burstcount,
  output logic                     ctrl_busy,
  output logic                     ctrl_done
`ifdef BURST_READ_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]    ctrl_checksum
`endif
);
  localparam int unsigned MAX_BURST = 1 << (BURST_WIDTH - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_C = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  burst_state_e              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic                      read_q, read_d;
  logic [BURST_WIDTH-1:0]    burstcount_q, burstcount_d;
  logic [BURST_WIDTH-1:0]    burst_max_q, burst_max_d;
  logic [BURST_WIDTH-1:0]    beats_q, beats_d;
  logic [LENGTH_WIDTH-1:0]   remaining_q, remaining_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
`ifdef BURST_READ_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]     sum_q, sum_d;
`endif

  logic                      push, pop, fifo_empty;
  logic [DATA_WIDTH-1:0]     fifo_data;
  logic [FIFO_DEPTH_LOG2:0]  fifo_count, free_slots;
  logic [BURST_WIDTH-1:0]    burst_len;

  // Beats arriving outside RECEIVE (e.g. leftovers of an aborted transfer) are dropped.
  assign push       = bus.master_readdatavalid && (state_q == ST_RECEIVE);
  assign pop        = !fifo_empty && bus.user_ready;
  assign free_slots = DEPTH_C - fifo_count;

  always_comb begin
    if (remaining_q < LENGTH_WIDTH'(burst_max_q)) burst_len = BURST_WIDTH'(remaining_q);
    else                                          burst_len = burst_max_q;
  end

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    read_d       = read_q;
    burstcount_d = burstcount_q;
    burst_max_d  = burst_max_q;
    beats_d      = beats_q;
    remaining_d  = remaining_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          address_d   = ctrl_baseaddress;
          remaining_d = ctrl_length;
          burst_max_d = BURST_WIDTH'(clamp_burst(32'(ctrl_burstcount), MAX_BURST));
          busy_d      = 1'b1;
          state_d     = (ctrl_length == '0) ? ST_FINISH : ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Only issue a burst the FIFO can absorb in full, so it never overflows.
        if (free_slots >= (FIFO_DEPTH_LOG2 + 1)'(burst_len)) begin
          burstcount_d = burst_len;
          beats_d      = burst_len;
          read_d       = 1'b1;
          state_d      = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (!bus.master_waitrequest) begin
          read_d    = 1'b0;
          address_d = address_q + ADDRESS_WIDTH'(32'(burstcount_q) * BYTE_ENABLE_WIDTH);
          state_d   = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (push) begin
          beats_d     = beats_q - 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (beats_q == BURST_WIDTH'(1))
            state_d = (remaining_q == LENGTH_WIDTH'(1)) ? ST_FINISH : ST_CHECK;
        end
      end
      ST_FINISH: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BURST_READ_CHECKSUM_EN
  always_comb begin
    sum_d = sum_q;
    if (state_q == ST_IDLE && ctrl_start) sum_d = '0;
    else if (push)                        sum_d = sum_q + bus.master_readdata;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      address_q    <= '0;
      read_q       <= 1'b0;
      burstcount_q <= '0;
      burst_max_q  <= '0;
      beats_q      <= '0;
      remaining_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef BURST_READ_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      read_q       <= read_d;
      burstcount_q <= burstcount_d;
      burst_max_q  <= burst_max_d;
      beats_q      <= beats_d;
      remaining_q  <= remaining_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef BURST_READ_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  burst_read_fifo #(
    .DATA_WIDTH     (DATA_WIDTH),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(bus.master_readdata),
    .pop      (pop),
    .pop_data (fifo_data),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign bus.master_address    = address_q;
  assign bus.master_read       = read_q;
  assign bus.master_burstcount = burstcount_q;
  assign bus.master_byteenable = '1;
  assign bus.user_data         = fifo_data;
  assign bus.user_valid        = !fifo_empty;
  assign ctrl_busy             = busy_q;
  assign ctrl_done             = done_q;
`ifdef BURST_READ_CHECKSUM_EN
  assign ctrl_checksum         = sum_q;
`endif

endmodule

// File: tb/tb_burst_read_master.sv
// Scoreboard bench for burst_read_master: a memory slave model, a transfer
// reference model feeding expected bursts/words, and a negedge monitor.
module tb_burst_read_master;
  localparam int AW = 32, DW = 32, BEW = 4, BW = 4, LW = 16, DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic ctrl_start;
  logic [AW-1:0] ctrl_baseaddress;
  logic [LW-1:0] ctrl_length;
  logic [BW-1:0] ctrl_burstcount;
  logic ctrl_busy, ctrl_done;
`ifdef BURST_READ_CHECKSUM_EN
  logic [DW-1:0] ctrl_checksum;
`endif

  burst_read_master_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                         .BYTE_ENABLE_WIDTH(BEW), .BURST_WIDTH(BW)) bus ();

  burst_read_master #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_ENABLE_WIDTH(BEW), .BURST_WIDTH(BW),
    .LENGTH_WIDTH(LW), .FIFO_DEPTH(DEPTH), .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ctrl_start(ctrl_start), .ctrl_baseaddress(ctrl_baseaddress),
    .ctrl_length(ctrl_length), .ctrl_burstcount(ctrl_burstcount),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done)
`ifdef BURST_READ_CHECKSUM_EN
    , .ctrl_checksum(ctrl_checksum)
`endif
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model state
  typedef struct packed { logic [31:0] addr; logic [31:0] n; } burst_t;
  logic [31:0] exp_data_q[$];
  burst_t      exp_burst_q[$];
  logic [31:0] exp_sum = '0;
  bit          seq_mode = 1'b0;
  logic [31:0] seq_base = '0;

  // Environment knobs and shared counters
  int wait_cycles = 0;
  bit gap_mode = 1'b0;
  int ready_mode = 0;
  int pushed_total = 0, popped_total = 0, stale_cnt = 0;
  int acc_count = 0, done_count = 0, rise_cyc = 0, done_cyc = 0, rd_hi = 0;
  int start_cyc = 0;
  logic [31:0] slave_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (seq_mode) return ((a - seq_base) >> 2) + 32'd1;
    return (a ^ {a[15:0], a[31:16]}) + 32'h1357_9BDF;
  endfunction

  // Words are the memory contents at base + 4*i; bursts chop the length into
  // chunks of the clamped burst size.
  task automatic push_model(input logic [31:0] base, input int len, input int bc);
    int b, rem, n;
    logic [31:0] a, w;
    b = (bc == 0) ? 1 : ((bc > 8) ? 8 : bc);
    exp_sum = '0;
    for (int i = 0; i < len; i++) begin
      w = mem_word(base + 32'(4 * i));
      exp_data_q.push_back(w);
      exp_sum += w;
    end
    rem = len;
    a = base;
    while (rem > 0) begin
      n = (rem < b) ? rem : b;
      exp_burst_q.push_back('{a, 32'(n)});
      a += 32'(4 * n);
      rem -= n;
    end
  endtask

  task automatic drive_start(input logic [31:0] base, input int len, input int bc, input bit model);
    @(posedge clk); #1;
    ctrl_start = 1'b1;
    ctrl_baseaddress = base;
    ctrl_length = LW'(len);
    ctrl_burstcount = BW'(bc);
    if (model) begin
      start_cyc = cyc;
      push_model(base, len, bc);
    end
    @(posedge clk); #1;
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int d0, k;
    d0 = done_count;
    k = 0;
    while (done_count == d0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(done_count != d0, "done_timeout", 32'(k), 32'(bound));
  endtask

  // Memory slave: accepts requests, stalls with waitrequest, returns beats.
  initial begin : slave
    int wr_left;
    bit req_active;
    wr_left = 0;
    req_active = 1'b0;
    bus.master_waitrequest = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stale_cnt = slave_q.size();
        pushed_total = 0;
      end else if (bus.master_read && !bus.master_waitrequest) begin
        for (int i = 0; i < int'(bus.master_burstcount); i++)
          slave_q.push_back(mem_word(bus.master_address + 32'(4 * i)));
      end
      @(posedge clk); #1;
      if (reset || !bus.master_read) begin
        req_active = 1'b0;
        bus.master_waitrequest = 1'b0;
      end else begin
        if (!req_active) begin
          req_active = 1'b1;
          wr_left = (wait_cycles < 0) ? int'($urandom_range(0, 3)) : wait_cycles;
        end
        bus.master_waitrequest = (wr_left > 0);
        if (wr_left > 0) wr_left--;
      end
      if (slave_q.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata = slave_q.pop_front();
        if (stale_cnt > 0) stale_cnt--;
        else pushed_total++;
      end else begin
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata = $urandom;
      end
    end
  end

  initial begin : sink
    bus.user_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.user_ready = 1'b1;
        1: bus.user_ready = ($urandom_range(0, 2) != 0);
        default: bus.user_ready = 1'b0;
      endcase
    end
  end

  // Monitor: bus requests, stream words and done pulses against the model.
  initial begin : monitor
    bit prev_rw, prev_read, prev_done;
    logic [31:0] prev_addr;
    logic [BW-1:0] prev_bc;
    burst_t eb;
    logic [31:0] ew;
    int occ;
    prev_rw = 0; prev_read = 0; prev_done = 0; prev_addr = '0; prev_bc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_data_q.delete();
        exp_burst_q.delete();
        prev_rw = 0; prev_read = 0; prev_done = 0;
        popped_total = 0;
        continue;
      end
      if (prev_rw) begin
        check(bus.master_read == 1'b1, "req_held_read", 32'(bus.master_read), 32'd1);
        check(bus.master_address == prev_addr, "req_held_addr", bus.master_address, prev_addr);
        check(bus.master_burstcount == prev_bc, "req_held_bc", 32'(bus.master_burstcount), 32'(prev_bc));
      end
      if (bus.master_read && !prev_read) begin
        rise_cyc = cyc;
        rd_hi = 0;
        occ = pushed_total - popped_total;
        check(occ + int'(bus.master_burstcount) <= DEPTH, "fifo_room",
              32'(occ), 32'(DEPTH - int'(bus.master_burstcount)));
      end
      if (bus.master_read) rd_hi++;
      if (bus.master_read && !bus.master_waitrequest) begin
        acc_count++;
        if (exp_burst_q.size() == 0) begin
          check(1'b0, "unexpected_request", bus.master_address, 32'd0);
        end else begin
          eb = exp_burst_q.pop_front();
          check(bus.master_address == eb.addr, "burst_addr", bus.master_address, eb.addr);
          check(32'(bus.master_burstcount) == eb.n, "burst_count", 32'(bus.master_burstcount), eb.n);
        end
      end
      if (bus.user_valid && bus.user_ready) begin
        popped_total++;
        if (exp_data_q.size() == 0) begin
          check(1'b0, "unexpected_word", bus.user_data, 32'd0);
        end else begin
          ew = exp_data_q.pop_front();
          check(bus.user_data == ew, "stream_word", bus.user_data, ew);
        end
      end
      if (ctrl_done) begin
        done_count++;
        done_cyc = cyc;
        check(!prev_done, "done_single_pulse", 32'(prev_done), 32'd0);
        check(!ctrl_busy, "busy_clear_at_done", 32'(ctrl_busy), 32'd0);
        check(exp_data_q.size() == 0, "words_left_at_done", 32'(exp_data_q.size()), 32'd0);
        check(exp_burst_q.size() == 0, "bursts_left_at_done", 32'(exp_burst_q.size()), 32'd0);
`ifdef BURST_READ_CHECKSUM_EN
        check(ctrl_checksum == exp_sum, "checksum", ctrl_checksum, exp_sum);
`endif
      end
      prev_rw   = bus.master_read && bus.master_waitrequest;
      prev_addr = bus.master_address;
      prev_bc   = bus.master_burstcount;
      prev_read = bus.master_read;
      prev_done = ctrl_done;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check(bus.master_read == 1'b0, {tag, "_read"}, 32'(bus.master_read), 32'd0);
    check(bus.master_address == '0, {tag, "_addr"}, bus.master_address, 32'd0);
    check(bus.master_burstcount == '0, {tag, "_bc"}, 32'(bus.master_burstcount), 32'd0);
    check(bus.master_byteenable == 4'hF, {tag, "_byteen"}, 32'(bus.master_byteenable), 32'hF);
    check(ctrl_busy == 1'b0, {tag, "_busy"}, 32'(ctrl_busy), 32'd0);
    check(ctrl_done == 1'b0, {tag, "_done"}, 32'(ctrl_done), 32'd0);
    check(bus.user_valid == 1'b0, {tag, "_uvalid"}, 32'(bus.user_valid), 32'd0);
    check(bus.user_data == '0, {tag, "_udata"}, bus.user_data, 32'd0);
`ifdef BURST_READ_CHECKSUM_EN
    check(ctrl_checksum == '0, {tag, "_checksum"}, ctrl_checksum, 32'd0);
`endif
  endtask

  initial begin : stimulus
    int a0, k, len, bc;
    logic [31:0] base;
    reset = 1'b1;
    ctrl_start = 1'b0;
    ctrl_baseaddress = '0;
    ctrl_length = '0;
    ctrl_burstcount = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single 8-beat burst, fixed latency, always-ready sink
    a0 = acc_count;
    drive_start(32'h3800_0000, 8, 8, 1'b1);
    wait_done(200);
    check(rise_cyc - start_cyc == 2, "first_read_latency", 32'(rise_cyc - start_cyc), 32'd2);
    check(acc_count - a0 == 1, "t1_requests", 32'(acc_count - a0), 32'd1);

    // 20 words in bursts of 8/8/4, with an ignored start mid-transfer
    a0 = acc_count;
    drive_start(32'h0, 20, 8, 1'b1);
    repeat (6) @(negedge clk);
    drive_start(32'h5000, 4, 2, 1'b0);
    wait_done(300);
    check(acc_count - a0 == 3, "t2_requests", 32'(acc_count - a0), 32'd3);

    // Slave stalls each request for 5 cycles
    wait_cycles = 5;
    a0 = acc_count;
    drive_start(32'h2000, 8, 8, 1'b1);
    wait_done(300);
    check(rd_hi == 6, "wait_read_cycles", 32'(rd_hi), 32'd6);
    check(acc_count - a0 == 1, "t3_requests", 32'(acc_count - a0), 32'd1);
    wait_cycles = 0;

    // Sink blocked: FIFO fills after two bursts and the master waits for room
    ready_mode = 2;
    a0 = acc_count;
    drive_start(32'h4000, 32, 8, 1'b1);
    repeat (80) @(negedge clk);
    check(acc_count - a0 == 2, "stall_requests", 32'(acc_count - a0), 32'd2);
    check(bus.master_read == 1'b0, "stall_no_read", 32'(bus.master_read), 32'd0);
    check(exp_data_q.size() == 32, "stall_words_held", 32'(exp_data_q.size()), 32'd32);
    ready_mode = 0;
    wait_done(500);
    check(acc_count - a0 == 4, "t4_requests", 32'(acc_count - a0), 32'd4);

    // Zero length: done after two cycles, no bus traffic
    a0 = acc_count;
    drive_start(32'h100, 0, 3, 1'b1);
    wait_done(50);
    check(done_cyc - start_cyc == 2, "len0_done_latency", 32'(done_cyc - start_cyc), 32'd2);
    check(acc_count - a0 == 0, "len0_requests", 32'(acc_count - a0), 32'd0);

    // Memory holding 1..8
    seq_mode = 1'b1;
    seq_base = 32'h8000;
    drive_start(32'h8000, 8, 8, 1'b1);
    wait_done(200);
`ifdef BURST_READ_CHECKSUM_EN
    check(ctrl_checksum == 32'd36, "checksum_1_to_8", ctrl_checksum, 32'd36);
`endif
    seq_mode = 1'b0;

    // Address wrap across 2^32
    drive_start(32'hFFFF_FFF0, 12, 8, 1'b1);
    wait_done(200);

    // Randomized transfers with stalls, data gaps and a bursty sink
    wait_cycles = -1;
    gap_mode = 1'b1;
    ready_mode = 1;
    for (int t = 0; t < 10; t++) begin
      base = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      len = int'($urandom_range(0, 40));
      bc = int'($urandom_range(0, 15));
      drive_start(base, len, bc, 1'b1);
      wait_done(3000);
    end
    wait_cycles = 0;
    gap_mode = 1'b0;
    ready_mode = 0;

    // Reset in the middle of a burst; late beats must not reach the stream
    drive_start(32'h9000, 16, 8, 1'b1);
    k = 0;
    while (!(bus.master_readdatavalid && !bus.master_read) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(k < 100, "receive_timeout", 32'(k), 32'd100);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check(ctrl_busy == 1'b0, "post_reset_busy", 32'(ctrl_busy), 32'd0);
    check(bus.user_valid == 1'b0, "post_reset_uvalid", 32'(bus.user_valid), 32'd0);
    check(bus.master_read == 1'b0, "post_reset_read", 32'(bus.master_read), 32'd0);

    // Normal operation resumes after the abort
    drive_start(32'hA000, 8, 4, 1'b1);
    wait_done(200);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_read_master.md
Name: burst_read_master

Overview:
- Avalon-MM burst read master. It reads a block of `ctrl_length` words from memory starting at `ctrl_baseaddress`, in bursts of up to `ctrl_burstcount` beats.
- Returned data passes through an internal FIFO to a valid/ready streaming consumer (display/DMA sink).
- It is the read-side counterpart of the team's burst write master and shares its control-port style: start, base address, burst count, busy.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- BYTE_ENABLE_WIDTH, 4, DATA_WIDTH/8; also the address stride per beat in bytes.
- BURST_WIDTH, 4, burstcount port width; maximum burst is 2^(BURST_WIDTH-1) = 8.
- LENGTH_WIDTH, 16, transfer length counter width, in words.
- FIFO_DEPTH, 16, buffer depth in words; must be ≥ 2^(BURST_WIDTH-1).
- FIFO_DEPTH_LOG2, 4, derived.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- master_address  out  ADDRESS_WIDTH  burst start byte address.
- master_read  out  1  read request.
- master_burstcount  out  BURST_WIDTH  beats in the current burst.
- master_byteenable  out  BYTE_ENABLE_WIDTH  constant all ones.
- master_waitrequest  in  1  slave stall.
- master_readdata  in  DATA_WIDTH  returned data.
- master_readdatavalid  in  1  returned data qualifier.
- ctrl_start  in  1  start pulse.
- ctrl_baseaddress  in  ADDRESS_WIDTH  start byte address.
- ctrl_length  in  LENGTH_WIDTH  total words to read.
- ctrl_burstcount  in  BURST_WIDTH  maximum beats per burst.
- ctrl_busy  out  1  transfer in progress.
- ctrl_done  out  1  one-cycle completion pulse.
- user_data  out  DATA_WIDTH  stream data.
- user_valid  out  1  stream valid.
- user_ready  in  1  stream ready.

Behaviour:
- **Reset:** all outputs are 0 except `master_byteenable`, which is all ones. FSM goes to IDLE, the FIFO is emptied and the counters are cleared. Reset mid-transfer abandons the transfer; any outstanding readdatavalid beats after reset are ignored.
- **FSM states:** IDLE, CHECK, REQUEST, RECEIVE, FINISH.
- **IDLE:**
  - `ctrl_start` = 1 latches `ctrl_baseaddress`, `ctrl_length` and `ctrl_burstcount`, and sets `ctrl_busy` = 1 on the next edge.
  - `ctrl_burstcount` = 0 is treated as 1. Values above 2^(BURST_WIDTH-1) are clamped to that maximum.
  - `ctrl_length` = 0 goes straight to FINISH with no bus traffic. Otherwise it goes to CHECK.
- **CHECK:**
  - Burst length = min(remaining, latched burstcount).
  - When FIFO free slots ≥ burst length: load `master_address` and `master_burstcount`, set `master_read` = 1, go to REQUEST.
  - Otherwise stay in CHECK. This guarantees the FIFO can never overflow.
  - The first `master_read` is asserted 2 cycles after `ctrl_start` is sampled.
- **REQUEST:**
  - Address, burstcount and read are held stable while `master_waitrequest` = 1.
  - On the cycle with waitrequest = 0, the request is accepted: `master_read` goes to 0 and the FSM moves to RECEIVE.
  - Address advances by burst length × BYTE_ENABLE_WIDTH. Address wrap at 2^ADDRESS_WIDTH is modulo.
- **RECEIVE:**
  - Each readdatavalid beat is pushed into the FIFO in the same cycle and decrements the beat counter and remaining count.
  - On the last beat: go to CHECK if remaining ≠ 0, else FINISH.
  - Only one burst is outstanding at a time.
  - readdatavalid in any state other than RECEIVE is dropped.
- **FINISH:**
  - Waits until the FIFO is empty, so all data has been delivered.
  - Then `ctrl_done` = 1 for one cycle, `ctrl_busy` = 0, and the FSM returns to IDLE.
  - `ctrl_start` while busy is ignored.
- **FIFO:**
  - Show-ahead behaviour, registered.
  - A push appears on `user_valid` no earlier than the next cycle.
  - A word transfers when `user_valid` & `user_ready`.
  - Simultaneous push and pop keeps the count unchanged. Push when full and pop when empty cannot occur; the FIFO asserts this in simulation.
  - The free-slot count used in CHECK is computed from the registered count.

Optional Feature:
- Macro: `BURST_READ_CHECKSUM_EN`.
- **When defined:**
  - Adds output port `ctrl_checksum` (DATA_WIDTH).
  - Holds the modulo-2^DATA_WIDTH sum of every beat pushed into the FIFO during the current transfer.
  - Cleared on the cycle `ctrl_start` is accepted; valid and stable from `ctrl_done` until the next start. Reset value is 0.
- **When undefined:** the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package `burst_pkg`: FSM state enum, the burst-size clamp function, and the beat-to-byte stride constant. It is shared with the burst write master.
- One sub-module: `burst_read_fifo`, a synchronous FIFO with `count` output, parameterised by DATA_WIDTH, FIFO_DEPTH and FIFO_DEPTH_LOG2.

Test Plan:
- Base 0x38000000, length 8, burstcount 8, waitrequest 0, user_ready 1, 1-cycle read latency:
  - one burst: address 0x38000000, burstcount 8;
  - 8 words out in order;
  - `ctrl_done` is a single pulse.
- Length 20, burstcount 8: bursts at 0x0/8, 0x20/8, 0x40/4; last burstcount is 4; 20 words delivered.
- waitrequest held high for 5 cycles during REQUEST: address, burstcount and read remain stable; exactly one request is accepted.
- user_ready = 0, length 32, burstcount 8, FIFO_DEPTH 16:
  - after 2 bursts the FSM stalls in CHECK;
  - no third request until ≥ 8 slots are free;
  - no word is lost.
- Length 0 → `ctrl_done` 2 cycles after start, `master_read` never asserted. A start while busy is ignored.
- Reset asserted mid-RECEIVE → all outputs 0 immediately; late readdatavalid is not pushed. With `BURST_READ_CHECKSUM_EN`, words 1..8 give `ctrl_checksum` = 36.
